// File: rtl/dma_issue_arbiter.sv
// dma_issue_arbiter
//   Shares the single dma_engine issue port between NREQ prefetch requesters.
//   Allocates DMA tags (lowest free first), enforces global and per-requester
//   outstanding limits, and routes dma_done completions back to the owner.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   per-requester handshake; req_ready is a one-hot grant
//   req_base/req_len  per-requester address/length, 32 bits per requester
//   dma_issue_*       registered issue channel towards dma_engine
//   dma_done_*        completion strobe and tag from dma_engine
//   cpl_valid/cpl_tag one-hot completion pulse to the owning requester
//   outstanding       number of allocated tags
//   err_spurious      sticky: done seen for a tag that is not allocated
module dma_issue_arbiter #(
  parameter int NREQ            = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PER_REQ_MAX     = 2,
  parameter int TAG_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_base,
  input  logic [NREQ*32-1:0]   req_len,
  output logic [NREQ-1:0]      req_ready,
  output logic                 dma_issue_valid,
  output logic [31:0]          dma_issue_base,
  output logic [31:0]          dma_issue_len,
  output logic [TAG_W-1:0]     dma_issue_tag,
  input  logic                 dma_issue_ready,
  input  logic                 dma_done_valid,
  input  logic [TAG_W-1:0]     dma_done_tag,
  output logic [NREQ-1:0]      cpl_valid,
  output logic [TAG_W-1:0]     cpl_tag,
  output logic [4:0]           outstanding,
  output logic                 err_spurious
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TID_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(PER_REQ_MAX + 1);

  // Tag table, per-requester counters and round-robin pointer
  logic [MAX_OUTSTANDING-1:0] busy_q, busy_d;
  logic [IDX_W-1:0]           owner_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0]           owner_d [MAX_OUTSTANDING];
  logic [CNT_W-1:0]           cnt_q   [NREQ];
  logic [CNT_W-1:0]           cnt_d   [NREQ];
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;

  // Issue register
  logic                       iss_valid_q, iss_valid_d;
  logic [31:0]                iss_base_q, iss_base_d;
  logic [31:0]                iss_len_q, iss_len_d;
  logic [TAG_W-1:0]           iss_tag_q, iss_tag_d;

  // Completion / status
  logic [NREQ-1:0]            cpl_valid_q, cpl_valid_d;
  logic [TAG_W-1:0]           cpl_tag_q, cpl_tag_d;
  logic [4:0]                 outst_q, outst_d;
  logic                       err_q, err_d;

  // Combinational helpers
  logic                       issue_free;
  logic                       free_found;
  logic [TID_W-1:0]           free_idx;
  logic [(1<<IDX_W)-1:0]      elig;
  logic [IDX_W:0]             cand;
  logic                       grant_vld;
  logic [IDX_W-1:0]           grant_idx;
  logic [31:0]                sel_base, sel_len;
  logic                       done_hit;
  logic [TID_W-1:0]           done_idx;
  logic [IDX_W-1:0]           done_owner;

  // Allocation uses only pre-edge tag state, so a tag freed this cycle is
  // not reusable until the next one.
  always_comb begin
    issue_free = !iss_valid_q || dma_issue_ready;

    free_found = 1'b0;
    free_idx   = '0;
    for (int t = MAX_OUTSTANDING - 1; t >= 0; t--) begin
      if (!busy_q[t]) begin
        free_found = 1'b1;
        free_idx   = TID_W'(t);
      end
    end

    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CNT_W'(PER_REQ_MAX)) &&
                free_found && issue_free;
    end

    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) cand = cand - (IDX_W+1)'(NREQ);
      if (!grant_vld && elig[cand[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
    // No grant may be visible while reset is asserted.
    grant_vld = grant_vld && rst_n;

    sel_base = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_base = req_base[32*i +: 32];
        sel_len  = req_len[32*i +: 32];
      end
    end
  end

  // Completion lookup; tags outside the table never match and count as spurious.
  always_comb begin
    done_hit   = 1'b0;
    done_idx   = '0;
    done_owner = '0;
    for (int t = 0; t < MAX_OUTSTANDING; t++) begin
      if (dma_done_valid && busy_q[t] && (dma_done_tag == TAG_W'(t))) begin
        done_hit   = 1'b1;
        done_idx   = TID_W'(t);
        done_owner = owner_q[t];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant_vld && (grant_idx == IDX_W'(i));
    end
  end

  always_comb begin
    busy_d      = busy_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    iss_valid_d = iss_valid_q;
    iss_base_d  = iss_base_q;
    iss_len_d   = iss_len_q;
    iss_tag_d   = iss_tag_q;
    cpl_valid_d = '0;
    cpl_tag_d   = cpl_tag_q;
    outst_d     = outst_q;
    err_d       = err_q | (dma_done_valid & ~done_hit);

    for (int t = 0; t < MAX_OUTSTANDING; t++) begin
      if (done_hit && (done_idx == TID_W'(t))) busy_d[t] = 1'b0;
      if (grant_vld && (free_idx == TID_W'(t))) begin
        busy_d[t]  = 1'b1;
        owner_d[t] = grant_idx;
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && (grant_idx == IDX_W'(i))) cnt_d[i] = cnt_d[i] + CNT_W'(1);
      if (done_hit && (done_owner == IDX_W'(i))) begin
        cnt_d[i]       = cnt_d[i] - CNT_W'(1);
        cpl_valid_d[i] = 1'b1;
      end
    end

    if (done_hit) cpl_tag_d = dma_done_tag;

    case ({grant_vld, done_hit})
      2'b10:   outst_d = outst_q + 5'd1;
      2'b01:   outst_d = outst_q - 5'd1;
      default: outst_d = outst_q;
    endcase

    if (grant_vld) begin
      rr_ptr_d = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end

    // Outputs hold while the engine stalls; an empty/accepted slot reloads.
    if (issue_free) begin
      iss_valid_d = grant_vld;
      if (grant_vld) begin
        iss_base_d = sel_base;
        iss_len_d  = sel_len;
        iss_tag_d  = TAG_W'(free_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      for (int t = 0; t < MAX_OUTSTANDING; t++) owner_q[t] <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      rr_ptr_q    <= '0;
      iss_valid_q <= 1'b0;
      iss_base_q  <= '0;
      iss_len_q   <= '0;
      iss_tag_q   <= '0;
      cpl_valid_q <= '0;
      cpl_tag_q   <= '0;
      outst_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      iss_valid_q <= iss_valid_d;
      iss_base_q  <= iss_base_d;
      iss_len_q   <= iss_len_d;
      iss_tag_q   <= iss_tag_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_tag_q   <= cpl_tag_d;
      outst_q     <= outst_d;
      err_q       <= err_d;
    end
  end

  assign dma_issue_valid = iss_valid_q;
  assign dma_issue_base  = iss_base_q;
  assign dma_issue_len   = iss_len_q;
  assign dma_issue_tag   = iss_tag_q;
  assign cpl_valid       = cpl_valid_q;
  assign cpl_tag         = cpl_tag_q;
  assign outstanding     = outst_q;
  assign err_spurious    = err_q;

endmodule

// File: tb/tb_dma_issue_arbiter.sv
// Self-checking bench for dma_issue_arbiter (NREQ=3, 4 tags, 2 per requester).
// Expected issues/completions are queued when stimulus is driven and popped
// when the DUT presents them.
module tb_dma_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [95:0] req_base = '0;
  logic [95:0] req_len = '0;
  logic [2:0]  req_ready;
  logic        dma_issue_valid;
  logic [31:0] dma_issue_base;
  logic [31:0] dma_issue_len;
  logic [7:0]  dma_issue_tag;
  logic        dma_issue_ready = 1'b0;
  logic        dma_done_valid = 1'b0;
  logic [7:0]  dma_done_tag = '0;
  logic [2:0]  cpl_valid;
  logic [7:0]  cpl_tag;
  logic [4:0]  outstanding;
  logic        err_spurious;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] len;
    logic [7:0]  tag;
  } iss_t;

  typedef struct packed {
    logic [2:0] vec;
    logic [7:0] tag;
  } cpl_t;

  iss_t iss_q[$];
  cpl_t cpl_q[$];
  iss_t ei;
  cpl_t ec;
  int   errors = 0;
  int   checks = 0;

  dma_issue_arbiter #(
    .NREQ(3), .MAX_OUTSTANDING(4), .PER_REQ_MAX(2), .TAG_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_base(req_base), .req_len(req_len),
    .req_ready(req_ready),
    .dma_issue_valid(dma_issue_valid), .dma_issue_base(dma_issue_base),
    .dma_issue_len(dma_issue_len), .dma_issue_tag(dma_issue_tag),
    .dma_issue_ready(dma_issue_ready),
    .dma_done_valid(dma_done_valid), .dma_done_tag(dma_done_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] b, input logic [31:0] l);
    req_base[32*r +: 32] = b;
    req_len[32*r +: 32]  = l;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    dma_issue_ready = 1'b0;
    dma_done_valid = 1'b0;
    dma_done_tag = '0;
    iss_q.delete();
    cpl_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] fbase(input int r, input int s);
    return 32'h3000_0000 + 32'(r << 16) + 32'(s * 16);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 3'b111;
    set_req(0, 32'hdead_0000, 32'd4);
    #1;
    checks++;
    if (req_ready !== 3'b000 || dma_issue_valid !== 1'b0 || cpl_valid !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b issue_valid=%b cpl=%b required 000/0/000",
               req_ready, dma_issue_valid, cpl_valid);
    end
    checks++;
    if (outstanding !== 5'd0 || err_spurious !== 1'b0 || dma_issue_tag !== 8'd0 ||
        dma_issue_base !== 32'd0 || dma_issue_len !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: outst=%0d err=%b tag=%0d base=%h len=%h required all 0",
               outstanding, err_spurious, dma_issue_tag, dma_issue_base, dma_issue_len);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    dma_issue_ready = 1'b1;
    set_req(0, 32'h1000_0000, 32'd256);
    req_valid = 3'b001;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL single_grant: got %b required 001", req_ready);
    end
    iss_q.push_back('{32'h1000_0000, 32'd256, 8'd0});
    tick();
    req_valid = '0;
    checks++;
    if (iss_q.size() == 0) begin
      errors++; $display("FAIL single_issue: scoreboard empty");
    end else begin
      ei = iss_q.pop_front();
      if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base ||
          dma_issue_len !== ei.len || dma_issue_tag !== ei.tag) begin
        errors++;
        $display("FAIL single_issue: got v=%b %h/%0d/tag%0d required 1 %h/%0d/tag%0d",
                 dma_issue_valid, dma_issue_base, dma_issue_len, dma_issue_tag,
                 ei.base, ei.len, ei.tag);
      end
    end
    checks++;
    if (outstanding !== 5'd1) begin
      errors++; $display("FAIL single_outst1: got %0d required 1", outstanding);
    end
    dma_done_valid = 1'b1;
    dma_done_tag = 8'd0;
    cpl_q.push_back('{3'b001, 8'd0});
    tick();
    dma_done_valid = 1'b0;
    checks++;
    if (cpl_q.size() == 0) begin
      errors++; $display("FAIL single_cpl: scoreboard empty");
    end else begin
      ec = cpl_q.pop_front();
      if (cpl_valid !== ec.vec || cpl_tag !== ec.tag) begin
        errors++;
        $display("FAIL single_cpl: got %b tag%0d required %b tag%0d",
                 cpl_valid, cpl_tag, ec.vec, ec.tag);
      end
    end
    checks++;
    if (outstanding !== 5'd0 || dma_issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: outst=%0d issue_valid=%b required 0/0",
               outstanding, dma_issue_valid);
    end
    tick();
    checks++;
    if (cpl_valid !== 3'b000) begin
      errors++; $display("FAIL single_cpl_pulse: got %b required 000", cpl_valid);
    end
  endtask

  task automatic test_fairness();
    int seq[3];
    int n;
    int g;
    n = 12;
    seq = '{0, 0, 0};
    apply_reset();
    dma_issue_ready = 1'b1;
    for (int c = 0; c <= n + 3; c++) begin
      if (c >= 1 && c <= n) begin
        checks++;
        if (iss_q.size() == 0) begin
          errors++; $display("FAIL fair_issue c%0d: scoreboard empty", c);
        end else begin
          ei = iss_q.pop_front();
          if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base ||
              dma_issue_len !== ei.len || dma_issue_tag !== ei.tag) begin
            errors++;
            $display("FAIL fair_issue c%0d: got v=%b %h tag%0d required %h tag%0d",
                     c, dma_issue_valid, dma_issue_base, dma_issue_tag, ei.base, ei.tag);
          end
        end
      end
      if (c >= 4 && c <= n + 3) begin
        checks++;
        if (cpl_q.size() == 0) begin
          errors++; $display("FAIL fair_cpl c%0d: scoreboard empty", c);
        end else begin
          ec = cpl_q.pop_front();
          if (cpl_valid !== ec.vec || cpl_tag !== ec.tag) begin
            errors++;
            $display("FAIL fair_cpl c%0d: got %b tag%0d required %b tag%0d",
                     c, cpl_valid, cpl_tag, ec.vec, ec.tag);
          end
        end
      end
      // Each issue is completed two cycles after it appears on the port.
      if (c >= 3 && c - 3 < n) begin
        dma_done_valid = 1'b1;
        dma_done_tag = 8'((c - 3) % 4);
        cpl_q.push_back('{3'(1 << ((c - 3) % 3)), 8'((c - 3) % 4)});
      end else begin
        dma_done_valid = 1'b0;
      end
      if (c < n) begin
        req_valid = 3'b111;
        for (int r = 0; r < 3; r++) set_req(r, fbase(r, seq[r]), 32'd64);
      end else begin
        req_valid = '0;
      end
      #1;
      if (c < n) begin
        g = c % 3;
        checks++;
        if (req_ready !== 3'(1 << g)) begin
          errors++; $display("FAIL fair_grant c%0d: got %b required %b", c, req_ready, 3'(1 << g));
        end
        checks++;
        if (outstanding !== 5'((c < 3) ? c : 3)) begin
          errors++;
          $display("FAIL fair_outst c%0d: got %0d required %0d", c, outstanding, (c < 3) ? c : 3);
        end
        iss_q.push_back('{fbase(g, seq[g]), 32'd64, 8'(c % 4)});
        seq[g]++;
      end
      tick();
    end
    dma_done_valid = 1'b0;
    checks++;
    if (outstanding !== 5'd0) begin
      errors++; $display("FAIL fair_drain: got %0d required 0", outstanding);
    end
  endtask

  task automatic test_per_req_cap();
    apply_reset();
    dma_issue_ready = 1'b1;
    req_valid = 3'b001;
    for (int c = 0; c < 2; c++) begin
      set_req(0, 32'h6000_0000 + 32'(c * 16), 32'd8);
      #1;
      checks++;
      if (req_ready !== 3'b001) begin
        errors++; $display("FAIL cap_grant c%0d: got %b required 001", c, req_ready);
      end
      iss_q.push_back('{32'h6000_0000 + 32'(c * 16), 32'd8, 8'(c)});
      tick();
      checks++;
      ei = iss_q.pop_front();
      if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base || dma_issue_tag !== ei.tag) begin
        errors++;
        $display("FAIL cap_issue c%0d: got %h tag%0d required %h tag%0d",
                 c, dma_issue_base, dma_issue_tag, ei.base, ei.tag);
      end
    end
    set_req(0, 32'h6000_0020, 32'd8);
    dma_done_valid = 1'b1;
    dma_done_tag = 8'd0;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL cap_block: got %b required 000 (2 held, tags free)", req_ready);
    end
    tick();
    dma_done_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL cap_release: got %b required 001", req_ready);
    end
    iss_q.push_back('{32'h6000_0020, 32'd8, 8'd0});
    tick();
    req_valid = '0;
    checks++;
    ei = iss_q.pop_front();
    if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base || dma_issue_tag !== ei.tag) begin
      errors++;
      $display("FAIL cap_reissue: got %h tag%0d required %h tag%0d",
               dma_issue_base, dma_issue_tag, ei.base, ei.tag);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    dma_issue_ready = 1'b0;
    set_req(1, 32'h4000_0000, 32'h80);
    req_valid = 3'b010;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL bp_first_grant: got %b required 010", req_ready);
    end
    iss_q.push_back('{32'h4000_0000, 32'h80, 8'd0});
    tick();
    set_req(1, 32'h4100_0000, 32'h40);
    for (int c = 0; c < 5; c++) begin
      checks++;
      ei = iss_q[0];
      if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base ||
          dma_issue_len !== ei.len || dma_issue_tag !== ei.tag) begin
        errors++;
        $display("FAIL bp_hold c%0d: got v=%b %h/%h tag%0d required 1 %h/%h tag%0d",
                 c, dma_issue_valid, dma_issue_base, dma_issue_len, dma_issue_tag,
                 ei.base, ei.len, ei.tag);
      end
      #1;
      checks++;
      if (req_ready !== 3'b000) begin
        errors++; $display("FAIL bp_stall_ready c%0d: got %b required 000", c, req_ready);
      end
      tick();
    end
    dma_issue_ready = 1'b1;
    checks++;
    ei = iss_q.pop_front();
    if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base || dma_issue_tag !== ei.tag) begin
      errors++;
      $display("FAIL bp_accept: got %h tag%0d required %h tag%0d",
               dma_issue_base, dma_issue_tag, ei.base, ei.tag);
    end
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL bp_regrant: got %b required 010", req_ready);
    end
    iss_q.push_back('{32'h4100_0000, 32'h40, 8'd1});
    tick();
    req_valid = '0;
    checks++;
    ei = iss_q.pop_front();
    if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base ||
        dma_issue_len !== ei.len || dma_issue_tag !== ei.tag) begin
      errors++;
      $display("FAIL bp_second: got %h/%h tag%0d required %h/%h tag%0d",
               dma_issue_base, dma_issue_len, dma_issue_tag, ei.base, ei.len, ei.tag);
    end
  endtask

  task automatic test_tag_exhaustion();
    int seq[3];
    logic [2:0] exp_g [4];
    seq = '{0, 0, 0};
    exp_g = '{3'b001, 3'b010, 3'b001, 3'b010};
    apply_reset();
    dma_issue_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) begin
        checks++;
        ei = iss_q.pop_front();
        if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base || dma_issue_tag !== ei.tag) begin
          errors++;
          $display("FAIL ex_issue c%0d: got %h tag%0d required %h tag%0d",
                   c, dma_issue_base, dma_issue_tag, ei.base, ei.tag);
        end
      end
      req_valid = 3'b011;
      for (int r = 0; r < 3; r++) set_req(r, 32'h5000_0000 + 32'(r * 4096) + 32'(seq[r] * 16), 32'd32);
      #1;
      checks++;
      if (req_ready !== exp_g[c]) begin
        errors++; $display("FAIL ex_grant c%0d: got %b required %b", c, req_ready, exp_g[c]);
      end
      iss_q.push_back('{32'h5000_0000 + 32'((c % 2) * 4096) + 32'(seq[c % 2] * 16), 32'd32, 8'(c)});
      seq[c % 2]++;
      tick();
    end
    checks++;
    ei = iss_q.pop_front();
    if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base || dma_issue_tag !== ei.tag) begin
      errors++;
      $display("FAIL ex_issue c4: got %h tag%0d required %h tag%0d",
               dma_issue_base, dma_issue_tag, ei.base, ei.tag);
    end
    req_valid = 3'b111;
    for (int r = 0; r < 3; r++) set_req(r, 32'h5000_0000 + 32'(r * 4096) + 32'(seq[r] * 16), 32'd32);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 3'b000 || outstanding !== 5'd4) begin
        errors++;
        $display("FAIL ex_full c%0d: ready=%b outst=%0d required 000/4", c, req_ready, outstanding);
      end
      tick();
    end
    dma_done_valid = 1'b1;
    dma_done_tag = 8'd2;
    cpl_q.push_back('{3'b001, 8'd2});
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL ex_same_cycle_free: got %b required 000", req_ready);
    end
    tick();
    dma_done_valid = 1'b0;
    checks++;
    ec = cpl_q.pop_front();
    if (cpl_valid !== ec.vec || cpl_tag !== ec.tag || outstanding !== 5'd3) begin
      errors++;
      $display("FAIL ex_cpl: got %b tag%0d outst=%0d required %b tag%0d outst=3",
               cpl_valid, cpl_tag, outstanding, ec.vec, ec.tag);
    end
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL ex_regrant: got %b required 100", req_ready);
    end
    iss_q.push_back('{32'h5000_0000 + 32'(2 * 4096), 32'd32, 8'd2});
    tick();
    req_valid = '0;
    checks++;
    ei = iss_q.pop_front();
    if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base || dma_issue_tag !== ei.tag ||
        outstanding !== 5'd4) begin
      errors++;
      $display("FAIL ex_reissue: got %h tag%0d outst=%0d required %h tag%0d outst=4",
               dma_issue_base, dma_issue_tag, outstanding, ei.base, ei.tag);
    end
  endtask

  task automatic test_out_of_order();
    logic [2:0] rv [3];
    logic [7:0] done_order [3];
    rv = '{3'b111, 3'b110, 3'b100};
    done_order = '{8'd2, 8'd0, 8'd1};
    apply_reset();
    dma_issue_ready = 1'b1;
    set_req(0, 32'h7000_0000, 32'd16);
    set_req(1, 32'h7100_0000, 32'd32);
    set_req(2, 32'h7200_0000, 32'd0);
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) begin
        checks++;
        ei = iss_q.pop_front();
        if (dma_issue_valid !== 1'b1 || dma_issue_base !== ei.base ||
            dma_issue_len !== ei.len || dma_issue_tag !== ei.tag) begin
          errors++;
          $display("FAIL ooo_issue c%0d: got %h/%0d tag%0d required %h/%0d tag%0d",
                   c, dma_issue_base, dma_issue_len, dma_issue_tag, ei.base, ei.len, ei.tag);
        end
      end
      if (c < 3) begin
        req_valid = rv[c];
        #1;
        checks++;
        if (req_ready !== 3'(1 << c)) begin
          errors++; $display("FAIL ooo_grant c%0d: got %b required %b", c, req_ready, 3'(1 << c));
        end
        iss_q.push_back('{32'h7000_0000 + 32'(c * 32'h0100_0000),
                          (c == 0) ? 32'd16 : ((c == 1) ? 32'd32 : 32'd0), 8'(c)});
        tick();
      end
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) begin
        checks++;
        ec = cpl_q.pop_front();
        if (cpl_valid !== ec.vec || cpl_tag !== ec.tag) begin
          errors++;
          $display("FAIL ooo_cpl %0d: got %b tag%0d required %b tag%0d",
                   c, cpl_valid, cpl_tag, ec.vec, ec.tag);
        end
      end
      if (c < 3) begin
        dma_done_valid = 1'b1;
        dma_done_tag = done_order[c];
        cpl_q.push_back('{3'(1 << done_order[c]), done_order[c]});
      end else begin
        dma_done_valid = 1'b0;
      end
      tick();
    end
    checks++;
    if (outstanding !== 5'd0 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL ooo_drain: outst=%0d err=%b required 0/0", outstanding, err_spurious);
    end
  endtask

  task automatic test_error_reset();
    apply_reset();
    dma_done_valid = 1'b1;
    dma_done_tag = 8'd3;
    tick();
    dma_done_valid = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || cpl_valid !== 3'b000 || outstanding !== 5'd0) begin
      errors++;
      $display("FAIL err_free_tag: err=%b cpl=%b outst=%0d required 1/000/0",
               err_spurious, cpl_valid, outstanding);
    end
    tick();
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b required 1", err_spurious);
    end
    apply_reset();
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++; $display("FAIL err_reset_clear: got %b required 0", err_spurious);
    end
    dma_done_valid = 1'b1;
    dma_done_tag = 8'd9;
    tick();
    dma_done_valid = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || cpl_valid !== 3'b000) begin
      errors++;
      $display("FAIL err_range_tag: err=%b cpl=%b required 1/000", err_spurious, cpl_valid);
    end
    apply_reset();
    dma_issue_ready = 1'b1;
    set_req(0, 32'h8000_0000, 32'd64);
    set_req(1, 32'h8100_0000, 32'd64);
    req_valid = 3'b011;
    tick();
    req_valid = 3'b010;
    tick();
    req_valid = 3'b001;
    checks++;
    if (outstanding !== 5'd2 || dma_issue_valid !== 1'b1 || dma_issue_tag !== 8'd1) begin
      errors++;
      $display("FAIL rst_pre: outst=%0d v=%b tag%0d required 2/1/tag1",
               outstanding, dma_issue_valid, dma_issue_tag);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b000 || dma_issue_valid !== 1'b0 || dma_issue_base !== 32'd0 ||
        dma_issue_len !== 32'd0 || dma_issue_tag !== 8'd0 || cpl_valid !== 3'b000 ||
        cpl_tag !== 8'd0 || outstanding !== 5'd0 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: ready=%b v=%b base=%h len=%h tag=%0d cpl=%b outst=%0d err=%b required all 0",
               req_ready, dma_issue_valid, dma_issue_base, dma_issue_len, dma_issue_tag,
               cpl_valid, outstanding, err_spurious);
    end
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    dma_done_valid = 1'b1;
    dma_done_tag = 8'd0;
    tick();
    dma_done_valid = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || cpl_valid !== 3'b000 || outstanding !== 5'd0) begin
      errors++;
      $display("FAIL rst_stale_done: err=%b cpl=%b outst=%0d required 1/000/0",
               err_spurious, cpl_valid, outstanding);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_per_req_cap();
    test_backpressure();
    test_tag_exhaustion();
    test_out_of_order();
    test_error_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_issue_arbiter.md
Name: dma_issue_arbiter

Overview:
- Shares the single dma_engine issue port between NREQ prefetch requesters (reference-tile prefetch, current-tile prefetch, writeback).
- Allocates DMA tags and enforces global and per-requester outstanding limits.
- Routes dma_done completions back to the requester that owns the tag.
- Sits between the split prefetchers and dma_engine in the VCNPU memory path.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MAX_OUTSTANDING, 4, total tags in flight; tags are 0..MAX_OUTSTANDING-1 (max 16).
- PER_REQ_MAX, 2, maximum tags held by any one requester (1..MAX_OUTSTANDING).
- TAG_W, 8, tag width on the DMA interface.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_base  input  NREQ*32  per-requester base address; requester i occupies bits [32i+31:32i].
- req_len  input  NREQ*32  per-requester length in bytes, packed the same way.
- req_ready  output  NREQ  one-hot grant; the request transfers when req_valid&req_ready.
- dma_issue_valid  output  1  registered issue valid.
- dma_issue_base  output  32  issued base address.
- dma_issue_len  output  32  issued length.
- dma_issue_tag  output  TAG_W  allocated tag, zero-extended.
- dma_issue_ready  input  1  dma_engine accepts the issue.
- dma_done_valid  input  1  completion strobe.
- dma_done_tag  input  TAG_W  completed tag.
- cpl_valid  output  NREQ  one-hot completion pulse to the owner.
- cpl_tag  output  TAG_W  tag of the completion.
- outstanding  output  5  number of tags allocated.
- err_spurious  output  1  sticky flag: done received for a tag that is not allocated.

Behaviour:
- Reset (asynchronous, rst_n low) clears:
  - all outputs to 0, including dma_issue_valid, cpl_valid, outstanding and err_spurious;
  - the tag table (all tags free);
  - per-requester counters;
  - rr_ptr.
- Reset mid-operation discards in-flight tags. Completions arriving after reset release set err_spurious.
- Issue register:
  - Holds base, len, tag and valid.
  - It is free when !dma_issue_valid, or when dma_issue_valid&dma_issue_ready.
  - While dma_issue_valid&!dma_issue_ready, all dma_issue_* outputs hold stable and req_ready=0.
- Eligibility: requester i is eligible when req_valid[i], its own count < PER_REQ_MAX, a free tag exists, and the issue register is free.
- Grant (combinational, same cycle):
  - Round-robin search starting at rr_ptr.
  - The first eligible requester g gets req_ready[g]=1; at most one bit is set.
  - On the following edge:
    - the issue register loads req_base/req_len of g plus the lowest-index free tag, and sets valid;
    - the tag table records owner g;
    - count[g] increments;
    - rr_ptr becomes (g+1) mod NREQ.
  - With no grant, rr_ptr is unchanged.
- Issue latency: 1 cycle from the accepted request to dma_issue_valid. Back-to-back issues are possible every cycle when dma_issue_ready=1.
- Completion:
  - dma_done_valid with an allocated tag t (t < MAX_OUTSTANDING) produces, next cycle, cpl_valid[owner(t)]=1 for one cycle and cpl_tag=t.
  - Tag t is freed and count[owner] decrements.
  - Completions may arrive in any order.
- Spurious completion: dma_done_valid for an unallocated tag or for t>=MAX_OUTSTANDING sets err_spurious and causes no cpl and no state change. Only reset clears err_spurious.
- Simultaneous free and allocate in the same cycle:
  - Both take effect.
  - A tag freed this cycle is not eligible for allocation until the next cycle; the allocator uses pre-edge free state.
  - outstanding = previous + alloc - free.
  - When at the limit, a free does not enable a grant in the same cycle.
- outstanding never exceeds MAX_OUTSTANDING. When it equals MAX_OUTSTANDING, all req_ready are 0.
- Zero-length requests are forwarded unchanged; no special case.
- The arbiter never drops a request. Requesters must hold req_valid and data stable until req_ready.

Test Plan:
1. Single request: req0 base=0x1000_0000, len=256, issue_ready=1 -> req_ready[0] in cycle 0; dma_issue_valid=1, tag=0 in cycle 1; done tag 0 -> cpl_valid=3'b001, cpl_tag=0 one cycle later; outstanding returns to 0.
2. Fairness: all 3 requesters valid continuously, done returned 2 cycles after each issue -> grant order 0,1,2,0,1,2; no requester starves; the per-requester cap of 2 holds.
3. Backpressure: dma_issue_ready=0 for 5 cycles with req1 pending -> dma_issue_* hold stable; req_ready=0 throughout; issue accepted on the first cycle ready=1.
4. Tag exhaustion: 4 tags in flight -> req_ready stays 0. Done of tag 2 in the same cycle as req pending -> no grant that cycle; next cycle grant with tag 2.
5. Out-of-order completion: tags 0(req0), 1(req1), 2(req2) issued; done order 2,0,1 -> cpl_valid 100, 001, 010 with matching cpl_tag.
6. Error and reset: done tag 3 while free -> err_spurious=1, no cpl. Assert rst_n low mid-transfer with 2 tags out -> all outputs 0, outstanding=0; a later done -> err_spurious=1.
